// File: rtl/inst_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State encodings, fetch bundle and address helpers.
package inst_fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_IDLE   = 2'd0,
      FETCH_REQ    = 2'd1,
      FETCH_FULL   = 2'd2,
      FETCH_SQUASH = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_stage_if.sv
// Instruction memory request/ack bus.
// Fetch stage is master, memory is slave.
interface inst_fetch_stage_if;

   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ack,
      output rdata
   );

endinterface

// File: rtl/inst_fetch_stage_skid_buf.sv
// One-entry {instr, pc} skid buffer for the fetch stage.
// Clear beats load; load beats drain.
module fetch_skid_buf
   import inst_fetch_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         drain,
   input  logic         clear,
   input  fetch_entry_t din,
   output logic         full,
   output fetch_entry_t dout
);

   // occupancy flag and captured entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
         dout <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
         dout <= din;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/inst_fetch_stage.sv
// Fetch stage: PC, imem request FSM, skid buffer and id_* register.
// Redirect squashes in-flight data; decoder stall backs up into skid.
module inst_fetch_stage
   import inst_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   inst_fetch_stage_if.master        imem,
   input  logic                      redirect_valid,
   input  logic [31:0]               redirect_pc,
   input  logic                      id_stall,
   output logic                      id_valid,
   output logic [31:0]               id_instr,
   output logic [31:0]               id_pc,
   output logic [31:0]               id_npc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  tgt_q, tgt_d;
   logic [31:0]  rd_pc;
   logic         room;
   logic         id_load, id_from_skid, id_kill;
   logic         skid_load, skid_drain, skid_clear;
   logic         skid_full;
   fetch_entry_t skid_dout, mem_entry, id_src;

   assign rd_pc     = word_align(redirect_pc);
   assign room      = ~id_valid | ~id_stall;
   assign mem_entry = '{instr: imem.rdata, pc: pc_q};
   assign id_src    = id_from_skid ? skid_dout : mem_entry;

   assign imem.req  = (state_q == FETCH_REQ) | (state_q == FETCH_SQUASH);
   assign imem.addr = pc_q;

   fetch_skid_buf u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .drain (skid_drain),
      .clear (skid_clear),
      .din   (mem_entry),
      .full  (skid_full),
      .dout  (skid_dout)
   );

   // state, pc and pending redirect target registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH_IDLE;
         pc_q    <= RESET_PC;
         tgt_q   <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
      end
   end

   // next state, next pc and datapath steering
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      tgt_d        = tgt_q;
      id_load      = 1'b0;
      id_from_skid = 1'b0;
      id_kill      = 1'b0;
      skid_load    = 1'b0;
      skid_drain   = 1'b0;
      skid_clear   = 1'b0;
      if (redirect_valid) begin
         id_kill    = 1'b1;
         skid_clear = 1'b1;
      end
      unique case (state_q)
         FETCH_IDLE: begin
            state_d = FETCH_REQ;
            if (redirect_valid) pc_d = rd_pc;
         end
         FETCH_REQ: begin
            if (redirect_valid) begin
               if (imem.ack) begin
                  pc_d = rd_pc;
               end else begin
                  tgt_d   = rd_pc;
                  state_d = FETCH_SQUASH;
               end
            end else if (imem.ack) begin
               pc_d = pc_q + 32'd4;
               if (room) begin
                  id_load = 1'b1;
               end else begin
                  skid_load = 1'b1;
                  state_d   = FETCH_FULL;
               end
            end
         end
         FETCH_FULL: begin
            if (redirect_valid) begin
               pc_d    = rd_pc;
               state_d = FETCH_REQ;
            end else if (room) begin
               id_load      = skid_full;
               id_from_skid = 1'b1;
               skid_drain   = 1'b1;
               state_d      = FETCH_REQ;
            end
         end
         FETCH_SQUASH: begin
            if (redirect_valid) tgt_d = rd_pc;
            if (imem.ack) begin
               pc_d    = redirect_valid ? rd_pc : tgt_q;
               state_d = FETCH_REQ;
            end
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   // decoder-facing instruction register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid <= 1'b0;
         id_instr <= NOP_INSTR;
         id_pc    <= RESET_PC;
         id_npc   <= RESET_PC + 32'd4;
      end else if (id_kill) begin
         id_valid <= 1'b0;
      end else if (id_load) begin
         id_valid <= 1'b1;
         id_instr <= id_src.instr;
         id_pc    <= id_src.pc;
         id_npc   <= id_src.pc + 32'd4;
      end else if (id_valid && !id_stall) begin
         id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Testbench for inst_fetch_stage.
// Memory and decoder models with an in-order instruction scoreboard.
module tb_inst_fetch_stage;
   import inst_fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_stall = 1'b0;
   logic        id_valid;
   logic [31:0] id_instr, id_pc, id_npc;

   inst_fetch_stage_if imem ();

   inst_fetch_stage #(.RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_npc         (id_npc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [31:0] exp_pc;
   logic [31:0] prev_addr;
   logic [31:0] rd_tgt;
   bit          busy, redir_prev, hold_prev;
   bit          st_force, rd_force;
   int          wleft, ncons;
   int          wfix = 0;
   int          st_pct = 0;
   int          rd_pct = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
   endfunction

   function automatic logic [31:0] rand_tgt();
      if ($urandom_range(0, 3) == 0)
         return 32'hFFFF_FFE0 | ($urandom & 32'h1F);
      return $urandom & 32'h3FF;
   endfunction

   task automatic model_init();
      exp_pc     = 32'h0;
      busy       = 0;
      hold_prev  = 0;
      redir_prev = 0;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      imem.ack       = 1'b0;
      imem.rdata     = 32'h0;
      id_stall       = 1'b0;
      redirect_valid = 1'b0;
      st_force       = 0;
      rd_force       = 0;
      repeat (2) @(negedge clk);
      chk("rst_req", imem.req, 0);
      chk("rst_vld", id_valid, 0);
      chk("rst_ins", id_instr, 32'h0000_0013);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_npc", id_npc, 32'h4);
      rst = 1'b0;
      model_init();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (redir_prev) chk("rd_kill", id_valid, 0);
      if (id_valid) begin
         chk("id_pc", id_pc, exp_pc);
         chk("id_ins", id_instr, memw(exp_pc));
         chk("id_npc", id_npc, exp_pc + 32'd4);
      end
      if (hold_prev) begin
         chk("hold_req", imem.req, 1);
         chk("hold_adr", imem.addr, prev_addr);
      end
      if (imem.req) chk("align", imem.addr[1:0], 0);
      id_stall = st_force || ($urandom_range(0, 99) < st_pct);
      redirect_valid = rd_force || ($urandom_range(0, 99) < rd_pct);
      redirect_pc = rd_force ? rd_tgt : rand_tgt();
      rd_force = 0;
      if (imem.req) begin
         if (!busy) begin
            busy  = 1;
            wleft = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
         end
         if (wleft == 0) begin
            imem.ack   = 1'b1;
            imem.rdata = memw(imem.addr);
            busy       = 0;
         end else begin
            imem.ack   = 1'b0;
            imem.rdata = $urandom;
            wleft--;
         end
      end else begin
         busy       = 0;
         imem.ack   = 1'b0;
         imem.rdata = $urandom;
      end
      if (redirect_valid) begin
         exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (id_valid && !id_stall) begin
         exp_pc = exp_pc + 32'd4;
         ncons++;
      end
      redir_prev = redirect_valid;
      hold_prev  = imem.req && !imem.ack;
      prev_addr  = imem.addr;
   endtask

   initial begin
      int c0, nv;
      imem.ack   = 1'b0;
      imem.rdata = 32'h0;
      ncons      = 0;

      // T1 zero-wait streaming
      do_reset();
      wfix = 0;
      step();
      chk("t1_req", imem.req, 1);
      chk("t1_a0", imem.addr, 32'h0);
      chk("t1_v0", id_valid, 0);
      step();
      chk("t1_a1", imem.addr, 32'h4);
      chk("t1_v1", id_valid, 1);
      chk("t1_p1", id_pc, 32'h0);
      step();
      chk("t1_a2", imem.addr, 32'h8);
      chk("t1_p2", id_pc, 32'h4);
      chk("t1_n2", id_npc, 32'h8);

      // T2 three wait cycles
      wfix = 3;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_hold", imem.addr, 32'hC);
      end
      step();
      chk("t2_next", imem.addr, 32'h10);
      chk("t2_pc", id_pc, 32'hC);

      // T3 stall with ack landing in skid
      do_reset();
      wfix = 0;
      step();
      step();
      st_force = 1;
      step();
      chk("t3_p0", id_pc, 32'h4);
      step();
      chk("t3_req", imem.req, 0);
      step();
      step();
      step();
      st_force = 0;
      step();
      chk("t3_a", id_pc, 32'h4);
      step();
      chk("t3_bv", id_valid, 1);
      chk("t3_b", id_pc, 32'h8);
      step();
      chk("t3_cv", id_valid, 1);
      chk("t3_c", id_pc, 32'hC);

      // T4 redirect during a waiting request
      do_reset();
      wfix = 0;
      repeat (4) step();
      wfix     = 2;
      rd_force = 1;
      rd_tgt   = 32'h100;
      step();
      chk("t4_a0", imem.addr, 32'h10);
      wfix = 0;
      step();
      chk("t4_a1", imem.addr, 32'h10);
      chk("t4_v1", id_valid, 0);
      step();
      chk("t4_a2", imem.addr, 32'h10);
      step();
      chk("t4_tgt", imem.addr, 32'h100);
      chk("t4_v3", id_valid, 0);
      step();
      chk("t4_pc", id_pc, 32'h100);

      // T5 redirect + ack + stall together
      do_reset();
      wfix = 0;
      step();
      step();
      st_force = 1;
      rd_force = 1;
      rd_tgt   = 32'h203;
      step();
      st_force = 0;
      step();
      chk("t5_v", id_valid, 0);
      chk("t5_a", imem.addr, 32'h200);
      step();
      chk("t5_pc", id_pc, 32'h200);

      // T6 asynchronous reset mid-request
      wfix = 3;
      step();
      step();
      #2 rst = 1'b1;
      imem.ack = 1'b0;
      #1;
      chk("t6_req", imem.req, 0);
      chk("t6_vld", id_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      model_init();
      wfix = 0;
      step();
      chk("t6_a", imem.addr, 32'h0);
      step();
      chk("t6_pc", id_pc, 32'h0);

      // randomized traffic against the scoreboard
      do_reset();
      wfix   = -1;
      st_pct = 25;
      rd_pct = 6;
      c0 = ncons;
      for (int i = 0; i < 3000; i++) step();
      nv = ncons - c0;
      chk("rnd_prog", nv > 300, 1);
      st_pct = 0;
      rd_pct = 0;
      c0 = ncons;
      repeat (20) step();
      chk("live", (ncons - c0) >= 3, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
